sram_master_ctrl: RTL and testbench
===================================

Name: sram_master_ctrl

Overview:
Initiator-side controller for the single-port synchronous SRAM (CS/WE/RD strobes, one read port, one write port, both sampled on posedge Clk).
- Converts host burst requests into per-cycle SRAM strobe sequences.
- Streams write data in and read data out.
- Tracks the SRAM read latency and returns read beats with a last-beat marker and a completion pulse.

Parameters:
ADR, 8, SRAM address width and burst-length field width
DATA, 8, SRAM data width

Ports:
Clk  in  1  system clock, all logic on posedge
Rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host burst request valid
req_ready  out  1  controller idle and accepting a request
req_we  in  1  1 = write burst, 0 = read burst
req_addr  in  ADR  first beat address
req_len  in  ADR  beats minus one (0 = 1 beat, 2^ADR-1 = 2^ADR beats)
wdata_valid  in  1  write beat valid
wdata_ready  out  1  controller accepts a write beat this cycle
wdata  in  DATA  write beat data
rdata_valid  out  1  read beat valid (single-cycle pulse, no backpressure)
rdata  out  DATA  read beat data
rdata_last  out  1  qualifies the final read beat of a burst
done  out  1  one-cycle pulse at burst completion
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable
sram_rd  out  1  SRAM read enable
sram_addr  out  ADR  SRAM address
sram_din  out  DATA  SRAM write data
sram_dout  in  DATA  SRAM registered read data

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE.
  - All sram_* outputs, rdata, rdata_valid, rdata_last and done are 0.
  - Read-tracking pipeline is cleared.
  - req_ready becomes 1 once Rst_n deasserts.
- Reset mid-burst aborts the burst immediately: no done pulse and no further strobes. Whatever was already written to the SRAM stays written.
- sram_* outputs are registered. sram_we and sram_rd are never both 1. Both are 0 whenever sram_cs=0.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready=1, strobes 0.
  - On req_valid: latch addr, remaining count = req_len and direction.
  - Next state is WRITE if req_we=1, otherwise READ. req_ready=0 in every state except IDLE.
- WRITE:
  - wdata_ready=1.
  - Each cycle with wdata_valid=1, the next cycle presents sram_cs=1, sram_we=1, sram_rd=0, sram_addr=cur_addr, sram_din=wdata. Then cur_addr increments and count decrements.
  - A cycle with wdata_valid=0 presents sram_cs=0 (bubble); the burst resumes when data returns.
  - On acceptance of the final beat (count==0): next state IDLE. done=1 in the same cycle the final write strobe is presented.
- READ:
  - Issues one strobe per cycle with no bubbles: sram_cs=1, sram_rd=1, sram_we=0, sram_addr=cur_addr, then increment and decrement.
  - After issuing the final beat: next state DRAIN.
- Read latency:
  - Strobe presented in cycle t; SRAM updates sram_dout at the end of t; controller registers sram_dout at the end of t+1.
  - Result: rdata_valid=1 in cycle t+2, with rdata = memory[addr issued in t].
  - A 2-stage valid/last shift pipeline tracks beats in flight, giving throughput of 1 beat per cycle.
- DRAIN: strobes 0. Wait until the pipeline is empty, then go to IDLE.
- Read completion: rdata_last=1 and done=1 in the same cycle as the final rdata_valid.
- Address arithmetic: cur_addr + 1 wraps modulo 2^ADR (0xFF -> 0x00 for ADR=8). No depth checking is performed.
- rdata holds its last value while rdata_valid=0.
- wdata_ready=0 outside WRITE; wdata_valid in other states is ignored.
- req_valid while not IDLE is ignored; the host must hold it until req_ready.
- A new request is accepted in the cycle after done at the earliest; back-to-back bursts have a 1-cycle IDLE gap.

Test Plan:
- Reset: Rst_n=0 asserted mid-cycle -> all outputs 0 immediately. After release, req_ready=1 and sram_cs=0.
- Single write then read:
  - Write req_addr=0x05, len=0, wdata=0xA5 -> one strobe cs=1/we=1/addr=0x05/din=0xA5, with done on the same cycle.
  - Read addr=0x05 -> rdata_valid with rdata=0xA5 and rdata_last=1 exactly 2 cycles after the rd strobe.
- Burst with bubbles: write addr=0x10, len=3, data 0x11,0x22,0x33,0x44 with wdata_valid low for 2 cycles after beat 2 -> addresses 0x10..0x13, a 2-cycle cs=0 gap, and done on the 0x13 strobe.
- Pipelined read burst: read addr=0x10, len=3 -> 4 consecutive rd strobes, then 4 consecutive rdata_valid beats 0x11,0x22,0x33,0x44, with last and done on 0x44.
- Wrap-around: write addr=0xFE, len=2 -> strobes at 0xFE, 0xFF, 0x00. A read back of the same range returns the matching data.
- Reset mid-burst: read len=7, assert Rst_n=0 after 3 strobes -> no done and no further rdata_valid. A new request after release works normally.

Source files
------------

// File: rtl/sram_master_ctrl.sv
// -----------------------------------------------------------------------------
// sram_master_ctrl
//   Initiator-side controller for a single-port synchronous SRAM with
//   CS/WE/RD strobes. It turns host burst requests into one strobe per beat,
//   streams write beats in, and returns read beats with a last marker and a
//   completion pulse.
//
// Ports
//   Clk, Rst_n         clock (posedge) and asynchronous active-low reset
//   req_valid/ready    burst request handshake; req_we, req_addr, req_len
//                      (beats minus one) qualify the request
//   wdata_valid/ready  write beat handshake, wdata is the beat payload
//   rdata_valid        single-cycle read beat pulse (no backpressure),
//                      rdata payload, rdata_last marks the final beat
//   done               one-cycle pulse when a burst completes
//   sram_cs/we/rd      registered SRAM strobes, sram_addr/sram_din registered
//   sram_dout          SRAM registered read data
//
// Handshake semantics: a transfer happens on a rising Clk edge where both
// valid and ready are 1. Ready never depends on the same-cycle valid. The
// host holds valid and its payload stable until the transfer occurs.
// rdata_valid is a pure pulse: the host must take the beat in that cycle.
// -----------------------------------------------------------------------------
module sram_master_ctrl #(
  parameter int ADR  = 8,
  parameter int DATA = 8
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ADR-1:0]  req_addr,
  input  logic [ADR-1:0]  req_len,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  input  logic [DATA-1:0] wdata,
  output logic            rdata_valid,
  output logic [DATA-1:0] rdata,
  output logic            rdata_last,
  output logic            done,
  output logic            sram_cs,
  output logic            sram_we,
  output logic            sram_rd,
  output logic [ADR-1:0]  sram_addr,
  output logic [DATA-1:0] sram_din,
  input  logic [DATA-1:0] sram_dout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]     state;
  logic [ADR-1:0] cur_addr;
  logic [ADR-1:0] count;
  // Set on the first clock after reset release so req_ready stays low while
  // the block is held in reset.
  logic           active;

  // Read tracking: stage 0 is aligned with the rd strobe on the SRAM pins,
  // stage 1 with sram_dout carrying that beat's data.
  logic p0_v, p0_l;
  logic p1_v, p1_l;

  logic wr_fire;
  logic last_beat;

  // No new request in the done cycle, which gives the one-cycle gap between
  // back-to-back bursts.
  assign req_ready   = active && (state == IDLE) && !done;
  assign wdata_ready = (state == WRITE);
  assign wr_fire     = wdata_ready && wdata_valid;
  assign last_beat   = (count == '0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      count       <= '0;
      active      <= 1'b0;
      p0_v        <= 1'b0;
      p0_l        <= 1'b0;
      p1_v        <= 1'b0;
      p1_l        <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rdata_last  <= 1'b0;
      done        <= 1'b0;
      sram_cs     <= 1'b0;
      sram_we     <= 1'b0;
      sram_rd     <= 1'b0;
      sram_addr   <= '0;
      sram_din    <= '0;
    end else begin
      active  <= 1'b1;
      // Strobes default low; address/data hold their last value.
      sram_cs <= 1'b0;
      sram_we <= 1'b0;
      sram_rd <= 1'b0;
      p0_v    <= 1'b0;
      p0_l    <= 1'b0;

      // Beat presented on the pins in t reaches sram_dout in t+1 and is
      // registered here for the host in t+2.
      p1_v        <= p0_v;
      p1_l        <= p0_l;
      rdata_valid <= p1_v;
      rdata_last  <= p1_v && p1_l;
      if (p1_v) rdata <= sram_dout;

      done <= (wr_fire && last_beat) || (p1_v && p1_l);

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cur_addr <= req_addr;
            count    <= req_len;
            state    <= req_we ? WRITE : READ;
          end
        end
        WRITE: begin
          // Cycles without wdata_valid leave cs low (bubble).
          if (wr_fire) begin
            sram_cs   <= 1'b1;
            sram_we   <= 1'b1;
            sram_addr <= cur_addr;
            sram_din  <= wdata;
            cur_addr  <= cur_addr + ADR'(1);
            count     <= count - ADR'(1);
            if (last_beat) state <= IDLE;
          end
        end
        READ: begin
          sram_cs   <= 1'b1;
          sram_rd   <= 1'b1;
          sram_addr <= cur_addr;
          p0_v      <= 1'b1;
          p0_l      <= last_beat;
          cur_addr  <= cur_addr + ADR'(1);
          count     <= count - ADR'(1);
          if (last_beat) state <= DRAIN;
        end
        DRAIN: begin
          // Final beat leaving stage 1 empties the pipeline.
          if (p1_v && p1_l) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_master_ctrl
//   Self-checking bench for sram_master_ctrl. A behavioural SRAM drives
//   sram_dout; a reference memory holds what the host intended to write and
//   supplies the expected read data. Expected strobes and read beats are
//   queued when stimulus is driven and popped when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_sram_master_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_len;
  logic       wdata_valid;
  logic       wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid;
  logic [7:0] rdata;
  logic       rdata_last;
  logic       done;
  logic       sram_cs;
  logic       sram_we;
  logic       sram_rd;
  logic [7:0] sram_addr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout;

  sram_master_ctrl #(.ADR(8), .DATA(8)) dut (
    .Clk         (clk),
    .Rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .rdata_last  (rdata_last),
    .done        (done),
    .sram_cs     (sram_cs),
    .sram_we     (sram_we),
    .sram_rd     (sram_rd),
    .sram_addr   (sram_addr),
    .sram_din    (sram_din),
    .sram_dout   (sram_dout)
  );

  // ---------------- clock / reset ----------------
  int cyc;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM model ----------------
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (sram_cs && sram_we) mem[sram_addr] <= sram_din;
    if (sram_cs && sram_rd) sram_dout <= mem[sram_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]  ref_mem [256];
  logic [16:0] wr_q[$];       // {done, addr, din} per expected write strobe
  logic [7:0]  rd_addr_q[$];  // expected rd strobe addresses
  logic [8:0]  exp_q[$];      // {last, data} per expected read beat
  int          rd_cyc_q[$];   // cycles of observed rd strobes
  int          wr_cyc_q[$];   // cycles of observed write strobes
  int          rdv_cyc_q[$];  // cycles of observed read beats
  int          rd_strobes;
  logic [7:0]  wbuf [256];

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [16:0] we_e;
    logic [8:0]  re_e;
    int          t;
    if (rst_n) begin
      if (sram_cs) check("we_rd_excl", 32'(sram_we & sram_rd), 32'd0);
      else         check("strobe_idle", 32'({sram_we, sram_rd}), 32'd0);

      if (sram_cs && sram_we) begin
        if (wr_q.size() == 0) check("wr_unexpected", 32'(sram_addr), 32'hFFFF_FFFF);
        else begin
          we_e = wr_q.pop_front();
          check("wr_addr", 32'(sram_addr), 32'(we_e[15:8]));
          check("wr_din",  32'(sram_din),  32'(we_e[7:0]));
          check("wr_done", 32'(done),      32'(we_e[16]));
          wr_cyc_q.push_back(cyc);
        end
      end

      if (sram_cs && sram_rd) begin
        rd_strobes++;
        if (rd_addr_q.size() == 0) check("rd_unexpected", 32'(sram_addr), 32'hFFFF_FFFF);
        else check("rd_addr", 32'(sram_addr), 32'(rd_addr_q.pop_front()));
        rd_cyc_q.push_back(cyc);
      end

      if (rdata_valid) begin
        rdv_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("rdv_unexpected", 32'(rdata), 32'hFFFF_FFFF);
        else begin
          re_e = exp_q.pop_front();
          check("rdata",      32'(rdata),      32'(re_e[7:0]));
          check("rdata_last", 32'(rdata_last), 32'(re_e[8]));
          check("rd_done",    32'(done),       32'(re_e[8]));
        end
        if (rd_cyc_q.size() == 0) check("rd_latency_nostrobe", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          t = rd_cyc_q.pop_front();
          check("rd_latency", 32'(cyc - t), 32'd2);
        end
      end

      if (done) begin
        check("done_context", 32'((sram_cs & sram_we) | (rdata_valid & rdata_last)), 32'd1);
        check("ready_at_done", 32'(req_ready), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic we, input logic [7:0] a, input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_len   = len;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_timeout", 32'(n >= 100), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((wr_q.size() != 0 || exp_q.size() != 0 || rd_addr_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= 200), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Writes wbuf[0..len]; bubble_n idle cycles are inserted before beat bubble_at.
  task automatic write_burst(input logic [7:0] addr, input int len, input int bubble_at, input int bubble_n);
    logic [7:0] a;
    int n;
    wr_cyc_q.delete();
    for (int i = 0; i <= len; i++) begin
      a = addr + 8'(i);
      ref_mem[a] = wbuf[i];
      wr_q.push_back({(i == len), a, wbuf[i]});
    end
    send_req(1'b1, addr, 8'(len));
    for (int i = 0; i <= len; i++) begin
      if (i == bubble_at) begin
        repeat (bubble_n) begin
          @(negedge clk);
          wdata_valid = 1'b0;
        end
      end
      @(negedge clk);
      wdata_valid = 1'b1;
      wdata       = wbuf[i];
      n = 0;
      while (!wdata_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("wdata_ready_timeout", 32'(n >= 50), 32'd0);
    end
    @(negedge clk);
    wdata_valid = 1'b0;
    wait_drain();
    check("wr_beats", 32'(wr_cyc_q.size()), 32'(len + 1));
  endtask

  // Optional noise drives wdata_valid during the read, which must be ignored.
  task automatic read_burst(input logic [7:0] addr, input int len, input logic noise);
    logic [7:0] a;
    rd_cyc_q.delete();
    rdv_cyc_q.delete();
    for (int i = 0; i <= len; i++) begin
      a = addr + 8'(i);
      rd_addr_q.push_back(a);
      exp_q.push_back({(i == len), ref_mem[a]});
    end
    wdata_valid = noise;
    wdata       = 8'hEE;
    send_req(1'b0, addr, 8'(len));
    wait_drain();
    wdata_valid = 1'b0;
    check("rd_beats", 32'(rdv_cyc_q.size()), 32'(len + 1));
    if (rdv_cyc_q.size() == len + 1)
      check("rd_back_to_back", 32'(rdv_cyc_q[len] - rdv_cyc_q[0]), 32'(len));
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({req_ready, wdata_ready, rdata_valid, rdata_last, done,
                sram_cs, sram_we, sram_rd}) | 32'({sram_addr, sram_din, rdata}) ;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int n;
    int quiet;
    logic [7:0] ra;
    int rl;
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    rd_strobes = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    sram_dout   = 8'h00;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = 8'h00;
    req_len     = 8'h00;
    wdata_valid = 1'b0;
    wdata       = 8'h00;
    rst_n       = 1'b1;

    // Reset asserted mid-cycle: outputs clear immediately.
    #3 rst_n = 1'b0;
    #1 check("reset_outputs", all_outputs(), 32'd0);
    repeat (3) @(negedge clk);
    check("reset_held_outputs", all_outputs(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("cs_after_reset", 32'(sram_cs), 32'd0);
    check("wdata_ready_idle", 32'(wdata_ready), 32'd0);

    // Single write then read.
    wbuf[0] = 8'hA5;
    write_burst(8'h05, 0, -1, 0);
    read_burst(8'h05, 0, 1'b0);

    // Burst with a 2-cycle bubble after beat 2.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    write_burst(8'h10, 3, 2, 2);
    if (wr_cyc_q.size() == 4) begin
      check("wr_gap_01", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd1);
      check("wr_bubble_gap", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'd3);
      check("wr_gap_23", 32'(wr_cyc_q[3] - wr_cyc_q[2]), 32'd1);
    end

    // Pipelined read burst, with wdata_valid noise that must be ignored.
    read_burst(8'h10, 3, 1'b1);

    // Address wrap-around.
    wbuf[0] = 8'hC1; wbuf[1] = 8'hC2; wbuf[2] = 8'hC3;
    write_burst(8'hFE, 2, -1, 0);
    read_burst(8'hFE, 2, 1'b0);

    // Random bursts.
    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom_range(32'h20, 32'hF0));
      rl = $urandom_range(0, 6);
      for (int i = 0; i <= rl; i++) wbuf[i] = 8'($urandom_range(0, 255));
      write_burst(ra, rl, $urandom_range(0, rl), $urandom_range(0, 3));
      read_burst(ra, rl, 1'($urandom_range(0, 1)));
    end

    // Reset mid-burst: read len=7, reset after 3 strobes.
    for (int i = 0; i <= 7; i++) begin
      rd_addr_q.push_back(8'h10 + 8'(i));
      exp_q.push_back({(i == 7), ref_mem[8'h10 + 8'(i)]});
    end
    rd_cyc_q.delete();
    base = rd_strobes;
    send_req(1'b0, 8'h10, 8'd7);
    n = 0;
    while (rd_strobes < base + 3 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("abort_strobe_timeout", 32'(n >= 50), 32'd0);
    rst_n = 1'b0;
    #1 check("abort_reset_outputs", all_outputs(), 32'd0);
    rd_addr_q.delete();
    exp_q.delete();
    rd_cyc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      quiet += int'(sram_cs) + int'(rdata_valid) + int'(done);
    end
    check("abort_quiet", 32'(quiet), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_mem_kept", 32'(mem[8'h44 - 8'h34]), 32'(ref_mem[8'h10]));

    // Normal operation after the aborted burst.
    wbuf[0] = 8'h5A; wbuf[1] = 8'h6B;
    write_burst(8'h80, 1, -1, 0);
    read_burst(8'h80, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
